fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, drives the instruction memory address, and
//  captures {pc, instruction} into the IF/ID pipeline register for the decoder. Memory
//  reads land on the falling edge, so the word for the current PC is valid by the next
//  rising edge. Fetch is single-cycle per instruction, with stall, redirect and halt.
// PARAMETERS
//  ADDR_W    15            PC / memory byte-address width
//  DATA_W    32            instruction width
//  RESET_PC  15'h0000      PC loaded on reset
//  NOP_INSTR 32'h00000013  value driven on id_instr whenever id_valid=0
// PORTS
//  clk             in   1       clock; all state on rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  imem_addr       out  ADDR_W  byte address to instruction memory (= pc, combinational)
//  imem_rdata      in   DATA_W  instruction word, valid by rising edge after pc settles
//  id_ready        in   1       decoder accepts IF/ID contents this cycle
//  id_valid        out  1       IF/ID holds a valid instruction
//  id_instr        out  DATA_W  fetched instruction
//  id_pc           out  ADDR_W  address of id_instr
//  redirect_valid  in   1       taken branch/jump from EX
//  redirect_pc     in   ADDR_W  redirect target
//  halt_req        in   1       stop fetching
//  halted          out  1       fetch permanently stopped
//  fetch_fault     out  1       misaligned redirect detected (sticky)
// BEHAVIOUR
//  Clock clk, one domain; reset asynchronous, active-low (rst_n).
//  Reset: pc=RESET_PC, state=BOOT, id_valid=0, id_instr=NOP_INSTR, id_pc=0, halted=0, fetch_fault=0.
//  States: BOOT -> RUN -> HALT; HALT exits only via reset.
//  BOOT: one cycle, no capture (memory not yet read at pc); unconditionally -> RUN.
//  RUN, advance = !id_valid || id_ready. Priority per rising edge:
//   1 redirect_valid, redirect_pc[1:0]!=0: fetch_fault=1, id_valid=0, -> HALT.
//   2 redirect_valid aligned: pc<=redirect_pc, id_valid<=0 (flush); stall ignored.
//   3 halt_req: -> HALT; if advance, id_valid<=0; else IF/ID held until id_ready.
//   4 advance: id_instr<=imem_rdata, id_pc<=pc, id_valid<=1, pc<=pc+4.
//   5 else (stall): pc, id_* held; memory re-reads same pc each falling edge.
//  Redirect penalty: 1 bubble; instr at target captured 2 edges after redirect asserted.
//  HALT: pc frozen, redirect/halt_req ignored; pending IF/ID drains on id_ready, then
//   id_valid=0; halted=1 from the edge entering HALT.
//  pc arithmetic mod 2^ADDR_W: 15'h7FFC + 4 wraps to 15'h0000, no flag.
//  pc[1:0] always 00. id_instr = NOP_INSTR whenever id_valid=0.
//  rst_n low mid-operation: all state to reset values immediately, no partial capture.
// STRUCTURE
//  cpu_pkg: fetch_state_t {BOOT, RUN, HALT}, NOP_INSTR, PC_STEP=4, ADDR_W/DATA_W defaults.
//  Sub-module if_id_reg: IF/ID register with load/hold/flush controls and NOP fill.
//  fetch_unit keeps pc register, state machine and priority logic.
// TESTING (bench pairs fetch_unit with instruction memory preloaded with known words)
//  Reset release, id_ready=1 -> BOOT 1 cycle, then id_pc=0,4,8,... one per cycle, instrs match memory.
//  id_ready=0 for 3 cycles at id_pc=8 -> id_pc/id_instr held at 8, pc stays 12; resumes with 12, no loss.
//  redirect_valid, redirect_pc=0x40, plus id_ready=0 -> next edge id_valid=0, following edge id_pc=0x40.
//  redirect_pc=0x42 -> fetch_fault=1, halted=1, id_valid=0, pc frozen; later redirect ignored.
//  halt_req with id_ready=0 at id_pc=0x10 -> halted=1, id_valid stays 1 until id_ready, then 0.
//  Force pc to 0x7FFC via redirect -> next captured id_pc=0x0000; rst_n pulse mid-run -> reset values at once.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
// The fetch state machine and the IF/ID register both import this package.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int              DEFAULT_ADDR_W    = 15;
    localparam int              DEFAULT_DATA_W    = 32;
    localparam logic [31:0]     DEFAULT_NOP_INSTR = 32'h0000_0013;
    localparam int              PC_STEP           = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, hold or flush, with a NOP placed in the
// instruction slot whenever the entry is not valid.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = DEFAULT_ADDR_W,
    parameter int                DATA_W    = DEFAULT_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc
);

    // Flush wins over load; the pc field is kept on flush so only valid/instr change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and feeds
// the IF/ID register, with stall, redirect, halt and misaligned-redirect fault.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = DEFAULT_ADDR_W,
    parameter int                DATA_W    = DEFAULT_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              halted,
    output logic              fetch_fault
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic              load, flush, fault_set, advance;

    assign imem_addr = pc;
    assign halted    = (state == HALT);
    assign advance   = !id_valid || id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            fetch_fault <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (fault_set)
                fetch_fault <= 1'b1;
        end
    end

    // Priority: misaligned redirect, aligned redirect, halt, advance, stall.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        load       = 1'b0;
        flush      = 1'b0;
        fault_set  = 1'b0;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                    fault_set  = 1'b1;
                    flush      = 1'b1;
                    state_next = HALT;
                end else if (redirect_valid) begin
                    pc_next = redirect_pc;
                    flush   = 1'b1;
                end else if (halt_req) begin
                    state_next = HALT;
                    flush      = advance;
                end else if (advance) begin
                    load    = 1'b1;
                    pc_next = pc + ADDR_W'(PC_STEP);
                end
            end
            HALT: begin
                // A held entry leaves once the decoder takes it; nothing new arrives.
                flush = advance;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    if_id_reg #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .flush    (flush),
        .instr_in (imem_rdata),
        .pc_in    (pc),
        .valid    (id_valid),
        .instr    (id_instr),
        .pc       (id_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit paired with a falling-edge instruction memory
// whose words encode their own byte address.
module tb_fetch_unit;

    localparam int          ADDR_W = 15;
    localparam int          DATA_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              id_ready;
    logic              id_valid;
    logic [DATA_W-1:0] id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt_req;
    logic              halted;
    logic              fetch_fault;

    logic [DATA_W-1:0] mem [0:(1<<(ADDR_W-2))-1];

    int checks = 0;
    int fails  = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    always @(negedge clk) imem_rdata <= mem[imem_addr[ADDR_W-1:2]];

    function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
        return 32'hA500_0000 | {17'd0, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset away from any edge, checks reset values, releases on a falling edge.
    task automatic test_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== '0) begin
            fails++;
            $display("[TB] FAIL %s_ifid: got v=%b i=%h pc=%h expected v=0 i=%h pc=0", tag, id_valid, id_instr, id_pc, NOP);
        end
        checks++;
        if (imem_addr !== 15'h0000 || halted !== 1'b0 || fetch_fault !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s_state: got addr=%h halted=%b fault=%b expected 0/0/0", tag, imem_addr, halted, fetch_fault);
        end
        id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (id_valid !== 1'b0 || imem_addr !== 15'h0000) begin
            fails++;
            $display("[TB] FAIL %s_boot: got v=%b addr=%h expected v=0 addr=0000", tag, id_valid, imem_addr);
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 15'(4*k) || id_instr !== word_at(15'(4*k))) begin
                fails++;
                $display("[TB] FAIL stream_%0d: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h", k, id_valid, id_pc, id_instr, 15'(4*k), word_at(15'(4*k)));
            end
        end
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 15'h0008 || id_instr !== word_at(15'h0008) || imem_addr !== 15'h000C) begin
                fails++;
                $display("[TB] FAIL stall_%0d: got v=%b pc=%h i=%h addr=%h expected v=1 pc=0008 addr=000C", k, id_valid, id_pc, id_instr, imem_addr);
            end
        end
        id_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (id_pc !== 15'(12 + 4*k) || id_instr !== word_at(15'(12 + 4*k))) begin
                fails++;
                $display("[TB] FAIL resume_%0d: got pc=%h i=%h expected pc=%h", k, id_pc, id_instr, 15'(12 + 4*k));
            end
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 15'h0040; id_ready = 1'b0;
        tick();
        checks++;
        if (id_valid !== 1'b0 || id_instr !== NOP || imem_addr !== 15'h0040) begin
            fails++;
            $display("[TB] FAIL redirect_bubble: got v=%b i=%h addr=%h expected v=0 i=%h addr=0040", id_valid, id_instr, imem_addr, NOP);
        end
        redirect_valid = 1'b0; id_ready = 1'b1;
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 15'h0040 || id_instr !== word_at(15'h0040)) begin
            fails++;
            $display("[TB] FAIL redirect_target: got v=%b pc=%h i=%h expected v=1 pc=0040 i=%h", id_valid, id_pc, id_instr, word_at(15'h0040));
        end
    endtask

    task automatic test_halt();
        redirect_valid = 1'b1; redirect_pc = 15'h0010;
        tick();
        redirect_valid = 1'b0;
        tick();
        halt_req = 1'b1; id_ready = 1'b0;
        tick();
        halt_req = 1'b0;
        checks++;
        if (halted !== 1'b1 || id_valid !== 1'b1 || id_pc !== 15'h0010) begin
            fails++;
            $display("[TB] FAIL halt_enter: got halted=%b v=%b pc=%h expected 1/1/0010", halted, id_valid, id_pc);
        end
        redirect_valid = 1'b1; redirect_pc = 15'h0100;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b1 || imem_addr !== 15'h0014 || id_instr !== word_at(15'h0010)) begin
            fails++;
            $display("[TB] FAIL halt_hold: got v=%b addr=%h i=%h expected v=1 addr=0014 i=%h", id_valid, imem_addr, id_instr, word_at(15'h0010));
        end
        id_ready = 1'b1;
        tick();
        checks++;
        if (id_valid !== 1'b0 || id_instr !== NOP || halted !== 1'b1 || imem_addr !== 15'h0014) begin
            fails++;
            $display("[TB] FAIL halt_drain: got v=%b i=%h halted=%b addr=%h expected v=0 NOP halted=1 addr=0014", id_valid, id_instr, halted, imem_addr);
        end
    endtask

    task automatic test_wrap();
        tick();
        redirect_valid = 1'b1; redirect_pc = 15'h7FFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (id_pc !== 15'h7FFC || id_instr !== word_at(15'h7FFC) || imem_addr !== 15'h0000) begin
            fails++;
            $display("[TB] FAIL wrap_top: got pc=%h i=%h addr=%h expected pc=7FFC addr=0000", id_pc, id_instr, imem_addr);
        end
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 15'h0000 || id_instr !== word_at(15'h0000) || fetch_fault !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wrap_next: got v=%b pc=%h i=%h fault=%b expected v=1 pc=0000 fault=0", id_valid, id_pc, id_instr, fetch_fault);
        end
    endtask

    task automatic test_fault();
        tick();
        redirect_valid = 1'b1; redirect_pc = 15'h0042; id_ready = 1'b0;
        tick();
        checks++;
        if (fetch_fault !== 1'b1 || halted !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 15'h0008) begin
            fails++;
            $display("[TB] FAIL fault_set: got fault=%b halted=%b v=%b addr=%h expected 1/1/0 addr=0008", fetch_fault, halted, id_valid, imem_addr);
        end
        redirect_pc = 15'h0080; id_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (fetch_fault !== 1'b1 || halted !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 15'h0008) begin
            fails++;
            $display("[TB] FAIL fault_sticky: got fault=%b halted=%b v=%b addr=%h expected 1/1/0 addr=0008", fetch_fault, halted, id_valid, imem_addr);
        end
    endtask

    initial begin
        for (int w = 0; w < (1 << (ADDR_W-2)); w++)
            mem[w] = word_at(15'(w*4));
        rst_n = 1'b1;
        id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
        test_reset("reset");
        test_stream();
        test_stall();
        test_redirect();
        test_halt();
        test_reset("reset_halted");
        test_wrap();
        test_fault();
        test_reset("reset_fault");
        test_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
